note_tracker: RTL and testbench
===============================

NOTE_TRACKER -- requirements
Module: note_tracker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press or a release.
REQ-002 Parameter TICKS_PER_STEP, default 10: HOLD cycles per note_duration increment.
REQ-003 clk_in  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_in  input  1  asynchronous active-low reset.
REQ-005 keys_in  input  7  raw key levels; bit k high = key k pressed (k = 0..6).
REQ-006 key_played  output  3  index of tracked key; feeds the colour stage.
REQ-007 note_duration  output  3  quantised hold time, saturating at 7; feeds the colour stage.
REQ-008 note_active  output  1  high while a debounced note is held.
REQ-009 note_done  output  1  one-cycle pulse when a note ends.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, ATTACK, HOLD, RELEASE.
REQ-011 IDLE -> ATTACK when any filtered key is high; latch the candidate as the lowest-index high key; clear the debounce counter.
REQ-012 ATTACK: candidate high increments the debounce counter; candidate low returns to IDLE.
- Another key changing SHALL NOT affect ATTACK.
REQ-013 ATTACK -> HOLD when the debounce counter reaches DEBOUNCE_CYCLES; on that edge:
- key_played = candidate
- note_duration = 0
- note_active = 1
- step counter cleared
REQ-014 note_active SHALL rise exactly SYNC_LAT + DEBOUNCE_CYCLES + 1 cycles after the first clock edge that samples keys_in[k] high (SYNC_LAT per REQ-026/027).
REQ-015 HOLD: the step counter counts cycles and wraps at TICKS_PER_STEP.
- Each wrap increments note_duration by 1, saturating at 7.
- The step counter keeps running while note_duration is saturated.
REQ-016 HOLD -> RELEASE when the tracked key is filtered low.
- Presses on other keys in HOLD or RELEASE SHALL be ignored.
REQ-017 RELEASE: the step counter and note_duration SHALL continue per REQ-015.
- Tracked key low increments the debounce counter.
- Tracked key high returns to HOLD with note_duration unchanged.
REQ-018 RELEASE -> IDLE when the debounce counter reaches DEBOUNCE_CYCLES; on that edge note_active = 0 and note_done = 1 for exactly one cycle.
REQ-019 In IDLE and ATTACK, key_played and note_duration SHALL hold the values of the last completed note.
REQ-020 Release-to-re-press SHALL take at least one IDLE cycle; notes SHALL never overlap.
REQ-021 All outputs SHALL be registered; no combinational path from keys_in to any output.

Reset
REQ-022 While rst_in is low, all outputs SHALL be 0, the state SHALL be IDLE, and all counters and synchroniser flops SHALL be 0.
- Reset takes effect asynchronously, including mid-HOLD.
REQ-023 No note_done pulse SHALL be generated by reset.
REQ-024 rst_in deassertion SHALL be synchronised to clk_in.
REQ-025 A key already held at reset release SHALL be handled as a new press per REQ-011.

Configuration
REQ-026 With NOTE_TRACKER_SYNC_EN defined: each keys_in bit passes through a two-flop synchroniser before the FSM; SYNC_LAT = 2.
REQ-027 Without NOTE_TRACKER_SYNC_EN: keys_in is sampled directly as the filtered key; SYNC_LAT = 0.
- All other behaviour is identical.

Verification
All scenarios use DEBOUNCE_CYCLES=4, TICKS_PER_STEP=10 and NOTE_TRACKER_SYNC_EN defined.
REQ-028 keys_in[3] high for 100 cycles, then low -> note_active rises 7 cycles after the press and note_done pulses 7 cycles after the release.
- key_played = 3.
- note_duration reaches 7 at 70 HOLD cycles and stays 7.
REQ-029 keys_in[1] high for 35 cycles -> final note_duration = 3, key_played = 1, exactly one note_done pulse.
REQ-030 keys_in[4] high for 2 cycles only -> note_active stays 0, no note_done; key_played and note_duration unchanged.
REQ-031 keys_in[5] and keys_in[2] rise on the same cycle -> key_played = 2.
- Key 5 is ignored until key 2's note_done.
REQ-032 Release glitch: tracked key low for 2 cycles mid-HOLD -> note_active stays 1, no note_done, note_duration keeps advancing.
REQ-033 Reset mid-operation: rst_in low during HOLD with note_duration = 4 -> all outputs 0 immediately with no clock edge, and no note_done.
- After rst_in is released with the key still held, note_active rises again after 7 cycles (REQ-025).

Source files
------------

// File: rtl/note_tracker.sv
//==============================================================================
// Module      : note_tracker
// Description : Debounced single-note tracker for a 7-key keyboard. It follows
//               one key through IDLE/ATTACK/HOLD/RELEASE, reports which key is
//               held and for how long, and pulses once when the note ends.
//               Define NOTE_TRACKER_SYNC_EN to add two-flop key synchronisers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module note_tracker #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICKS_PER_STEP  = 10
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] keys_in,
    output logic [2:0] key_played,
    output logic [2:0] note_duration,
    output logic       note_active,
    output logic       note_done
);

    localparam int c_DB_W   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_STEP_W = (TICKS_PER_STEP < 2) ? 1 : $clog2(TICKS_PER_STEP);
    localparam logic [c_DB_W-1:0]   c_DB_MAX   = c_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_STEP_W-1:0] c_STEP_MAX = c_STEP_W'(TICKS_PER_STEP - 1);
    localparam logic [2:0]          c_DUR_MAX  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    logic [6:0] w_keys;

`ifdef NOTE_TRACKER_SYNC_EN
    logic [6:0] r_keys_meta;
    logic [6:0] r_keys_sync;

    always_ff @(posedge clk_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_keys_meta <= '0;
            r_keys_sync <= '0;
        end else begin
            r_keys_meta <= keys_in;
            r_keys_sync <= r_keys_meta;
        end
    end

    assign w_keys = r_keys_sync;
`else
    assign w_keys = keys_in;
`endif

    state_t                r_state;
    logic [2:0]            r_cand;
    logic [c_DB_W-1:0]     r_db_cnt;
    logic [c_STEP_W-1:0]   r_step_cnt;
    logic [2:0]            r_key_played;
    logic [2:0]            r_duration;
    logic                  r_active;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [2:0]            w_cand_nxt;
    logic [c_DB_W-1:0]     w_db_nxt;
    logic [c_STEP_W-1:0]   w_step_nxt;
    logic [2:0]            w_key_nxt;
    logic [2:0]            w_dur_nxt;
    logic                  w_active_nxt;
    logic                  w_done_nxt;

    logic [2:0]            w_low_idx;
    logic                  w_any_key;
    logic                  w_cand_key;
    logic                  w_step_wrap;

    always_comb begin
        w_low_idx = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (w_keys[k]) begin
                w_low_idx = 3'(k);
            end
        end
    end

    assign w_any_key   = |w_keys;
    assign w_cand_key  = w_keys[r_cand];
    assign w_step_wrap = (r_step_cnt == c_STEP_MAX);

    always_ff @(posedge clk_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_db_nxt     = r_db_cnt;
        w_step_nxt   = r_step_cnt;
        w_key_nxt    = r_key_played;
        w_dur_nxt    = r_duration;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_key) begin
                    w_state_nxt = ATTACK;
                    w_cand_nxt  = w_low_idx;
                    w_db_nxt    = '0;
                end
            end

            ATTACK: begin
                if (!w_cand_key) begin
                    w_state_nxt = IDLE;
                end else if (r_db_cnt == c_DB_MAX) begin
                    w_state_nxt  = HOLD;
                    w_key_nxt    = r_cand;
                    w_dur_nxt    = 3'd0;
                    w_active_nxt = 1'b1;
                    w_step_nxt   = '0;
                end else begin
                    w_db_nxt = r_db_cnt + c_DB_W'(1);
                end
            end

            HOLD, RELEASE: begin
                // Duration keeps accruing through a pending release.
                if (w_step_wrap) begin
                    w_step_nxt = '0;
                    if (r_duration != c_DUR_MAX) begin
                        w_dur_nxt = r_duration + 3'd1;
                    end
                end else begin
                    w_step_nxt = r_step_cnt + c_STEP_W'(1);
                end

                if (r_state == HOLD) begin
                    if (!w_cand_key) begin
                        w_state_nxt = RELEASE;
                        w_db_nxt    = '0;
                    end
                end else if (w_cand_key) begin
                    w_state_nxt = HOLD;
                end else if (r_db_cnt == c_DB_MAX) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + c_DB_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_cand       <= 3'd0;
            r_db_cnt     <= '0;
            r_step_cnt   <= '0;
            r_key_played <= 3'd0;
            r_duration   <= 3'd0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cand       <= w_cand_nxt;
            r_db_cnt     <= w_db_nxt;
            r_step_cnt   <= w_step_nxt;
            r_key_played <= w_key_nxt;
            r_duration   <= w_dur_nxt;
            r_active     <= w_active_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign key_played    = r_key_played;
    assign note_duration = r_duration;
    assign note_active   = r_active;
    assign note_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_note_tracker.sv
//==============================================================================
// Module      : tb_note_tracker
// Description : Directed self-checking bench for note_tracker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_note_tracker;

    localparam int DEBOUNCE = 4;
    localparam int TICKS    = 10;
`ifdef NOTE_TRACKER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Edges from first sampling edge to note_active rise (and release to note_done).
    localparam int C_HOLD  = SYNC_LAT + DEBOUNCE + 1;
    // Two-flop reset synchroniser delays the first functional edge.
    localparam int RST_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [6:0] keys;
    logic [2:0] key_played;
    logic [2:0] note_duration;
    logic       note_active;
    logic       note_done;

    int passed = 0;
    int total  = 0;

    note_tracker #(
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .TICKS_PER_STEP (TICKS)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .keys_in      (keys),
        .key_played   (key_played),
        .note_duration(note_duration),
        .note_active  (note_active),
        .note_done    (note_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        keys   = 7'd0;
        rst_in = 1'b1;
        #3;
        rst_in = 1'b0;
        #1;
        total++;
        if ({key_played, note_duration, note_active, note_done} !== 8'h00)
            $display("FAIL reset_outputs: got %h, expected 00",
                     {key_played, note_duration, note_active, note_done});
        else passed++;
        repeat (3) tick();
        rst_in = 1'b1;
        repeat (10) tick();
        total++;
        if ({key_played, note_duration, note_active, note_done} !== 8'h00)
            $display("FAIL idle_after_reset: got %h, expected 00",
                     {key_played, note_duration, note_active, note_done});
        else passed++;
    endtask

    task automatic test_long_note();
        int rise_at = -1;
        int done_at = -1;
        int done_cnt = 0;
        logic [2:0] dur_a = 3'd0;
        logic [2:0] dur_b = 3'd0;
        keys = 7'b0001000;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (note_active && rise_at < 0) rise_at = i;
            if (note_done) done_cnt++;
            if (i == C_HOLD + 69) dur_a = note_duration;
            if (i == C_HOLD + 70) dur_b = note_duration;
        end
        total++;
        if (rise_at !== C_HOLD) $display("FAIL long_rise: got %0d, expected %0d", rise_at, C_HOLD);
        else passed++;
        total++;
        if (dur_a !== 3'd6) $display("FAIL long_dur69: got %0d, expected 6", dur_a);
        else passed++;
        total++;
        if (dur_b !== 3'd7) $display("FAIL long_dur70: got %0d, expected 7", dur_b);
        else passed++;
        total++;
        if (note_duration !== 3'd7) $display("FAIL long_dur_sat: got %0d, expected 7", note_duration);
        else passed++;
        total++;
        if (key_played !== 3'd3) $display("FAIL long_key: got %0d, expected 3", key_played);
        else passed++;
        keys = 7'd0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (note_done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
        end
        total++;
        if (done_at !== C_HOLD) $display("FAIL long_done_lat: got %0d, expected %0d", done_at, C_HOLD);
        else passed++;
        total++;
        if (done_cnt !== 1) $display("FAIL long_done_cnt: got %0d, expected 1", done_cnt);
        else passed++;
        total++;
        if (note_active !== 1'b0) $display("FAIL long_active_end: got %b, expected 0", note_active);
        else passed++;
    endtask

    task automatic test_short_press();
        int seen_active = 0;
        int done_cnt = 0;
        keys = 7'b0010000;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) keys = 7'd0;
            tick();
            if (note_active) seen_active++;
            if (note_done) done_cnt++;
        end
        total++;
        if (seen_active !== 0) $display("FAIL short_press_active: got %0d cycles, expected 0", seen_active);
        else passed++;
        total++;
        if (done_cnt !== 0) $display("FAIL short_press_done: got %0d, expected 0", done_cnt);
        else passed++;
        total++;
        if (key_played !== 3'd3) $display("FAIL short_press_key: got %0d, expected 3", key_played);
        else passed++;
        total++;
        if (note_duration !== 3'd7) $display("FAIL short_press_dur: got %0d, expected 7", note_duration);
        else passed++;
    endtask

    task automatic test_short_note();
        int done_cnt = 0;
        keys = 7'b0000010;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (note_done) done_cnt++;
        end
        keys = 7'd0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (note_done) done_cnt++;
        end
        total++;
        if (note_duration !== 3'd3) $display("FAIL short_note_dur: got %0d, expected 3", note_duration);
        else passed++;
        total++;
        if (key_played !== 3'd1) $display("FAIL short_note_key: got %0d, expected 1", key_played);
        else passed++;
        total++;
        if (done_cnt !== 1) $display("FAIL short_note_done: got %0d, expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int rise_at = -1;
        int done_at = -1;
        int rise2_at = -1;
        int done_cnt = 0;
        logic [2:0] key_at_done = 3'd0;
        logic active_at_done = 1'b1;
        keys = 7'b0100100;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (note_active && rise_at < 0) rise_at = i;
        end
        total++;
        if (rise_at !== C_HOLD) $display("FAIL simul_rise: got %0d, expected %0d", rise_at, C_HOLD);
        else passed++;
        total++;
        if (key_played !== 3'd2) $display("FAIL simul_key: got %0d, expected 2", key_played);
        else passed++;
        keys = 7'b0100000;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (note_done && done_at < 0) begin
                done_at        = j;
                key_at_done    = key_played;
                active_at_done = note_active;
            end
            if (note_active && done_at >= 0 && j > done_at && rise2_at < 0) rise2_at = j;
        end
        total++;
        if (done_at !== C_HOLD) $display("FAIL simul_done_lat: got %0d, expected %0d", done_at, C_HOLD);
        else passed++;
        total++;
        if (key_at_done !== 3'd2) $display("FAIL simul_key_at_done: got %0d, expected 2", key_at_done);
        else passed++;
        total++;
        if (active_at_done !== 1'b0) $display("FAIL simul_overlap: got active %b at done, expected 0", active_at_done);
        else passed++;
        total++;
        if (rise2_at - done_at !== DEBOUNCE + 2)
            $display("FAIL simul_regap: got %0d, expected %0d", rise2_at - done_at, DEBOUNCE + 2);
        else passed++;
        total++;
        if (key_played !== 3'd5) $display("FAIL simul_key2: got %0d, expected 5", key_played);
        else passed++;
        keys = 7'd0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (note_done) done_cnt++;
        end
        total++;
        if (done_cnt !== 1) $display("FAIL simul_final_done: got %0d, expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_glitch();
        int dropped = 0;
        int done_cnt = 0;
        logic [2:0] dur_pre = 3'd0;
        keys = 7'b1000000;
        for (int i = 0; i < 52; i++) begin
            if (i == 30) keys = 7'd0;
            if (i == 32) keys = 7'b1000000;
            tick();
            if (i >= C_HOLD && !note_active) dropped++;
            if (note_done) done_cnt++;
            if (i == 29) dur_pre = note_duration;
        end
        total++;
        if (dropped !== 0) $display("FAIL glitch_active: got %0d low cycles, expected 0", dropped);
        else passed++;
        total++;
        if (done_cnt !== 0) $display("FAIL glitch_done: got %0d, expected 0", done_cnt);
        else passed++;
        total++;
        if (dur_pre !== 3'd2) $display("FAIL glitch_dur_pre: got %0d, expected 2", dur_pre);
        else passed++;
        total++;
        if (note_duration !== 3'd4) $display("FAIL glitch_dur_post: got %0d, expected 4", note_duration);
        else passed++;
        total++;
        if (key_played !== 3'd6) $display("FAIL glitch_key: got %0d, expected 6", key_played);
        else passed++;
        keys = 7'd0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (note_done) done_cnt++;
        end
        total++;
        if (done_cnt !== 1) $display("FAIL glitch_final_done: got %0d, expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_hold();
        int rise_at = -1;
        int done_cnt = 0;
        keys = 7'b0000001;
        for (int i = 0; i < C_HOLD + 45; i++) begin
            tick();
            if (note_done) done_cnt++;
        end
        total++;
        if (note_duration !== 3'd4 || note_active !== 1'b1)
            $display("FAIL rst_pre_state: got dur %0d active %b, expected dur 4 active 1",
                     note_duration, note_active);
        else passed++;
        #2;
        rst_in = 1'b0;
        #1;
        total++;
        if ({key_played, note_duration, note_active, note_done} !== 8'h00)
            $display("FAIL rst_async_outputs: got %h, expected 00",
                     {key_played, note_duration, note_active, note_done});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (note_done) done_cnt++;
        end
        rst_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (note_active && rise_at < 0) rise_at = i;
            if (note_done) done_cnt++;
        end
        total++;
        if (done_cnt !== 0) $display("FAIL rst_no_done: got %0d, expected 0", done_cnt);
        else passed++;
        total++;
        if (rise_at !== RST_LAT + C_HOLD)
            $display("FAIL rst_repress_rise: got %0d, expected %0d", rise_at, RST_LAT + C_HOLD);
        else passed++;
        keys = 7'd0;
        repeat (30) tick();
    endtask

    initial begin
        test_reset();
        test_long_note();
        test_short_press();
        test_short_note();
        test_simultaneous();
        test_glitch();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
